led_matrix_driver: RTL and testbench

Consumes the 16x16 red and green pixel frames produced by the traffic-light FSM and drives the physical dual-colour LED board. The board uses a serial column shift register plus a 4-bit row decoder. The block snapshots one frame, then scans rows 0..15: it shifts 32 column bits, pulses latch, and enables the row for a fixed on-time. It sits between the intersection FSM outputs and the board pins.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_row_shifter.sv | 65 ++++++
 rtl/led_matrix_driver.sv | 109 ++++++++++
 tb/tb_led_matrix_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared scan states and geometry for the dual-colour LED matrix driver
package led_pkg;

  typedef enum logic [1:0] {
    FRAME,
    SHIFT,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int ROWS         = 16;
  localparam int COLS         = 16;
  localparam int BITS_PER_ROW = 32;

endpackage

// File: rtl/led_row_shifter.sv
// rtl/led_row_shifter.sv - serialises one 32-bit row word MSB first onto sclk/sdata
module led_row_shifter
  import led_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BITS_PER_ROW-1:0] word,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BITS_PER_ROW);

  logic                    busy;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BITS_PER_ROW-1:0] shreg;
  logic                    phase_end;

  assign phase_end = busy && (div_cnt == DW'(DIV - 1));
  // Combinational so the scan FSM leaves SHIFT on the last high-phase cycle.
  assign done      = phase_end && sclk && (bit_cnt == BW'(BITS_PER_ROW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= word;
      sclk    <= 1'b0;
      sdata   <= word[BITS_PER_ROW-1];
    end else if (busy) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == BW'(BITS_PER_ROW - 1)) begin
            busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {shreg[BITS_PER_ROW-2:0], 1'b0};
            sdata   <= shreg[BITS_PER_ROW-2];
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_driver.sv
// rtl/led_matrix_driver.sv - snapshots a red/green frame and row-scans it onto the LED board
module led_matrix_driver
  import led_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int ON_TIME = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ROWS-1:0][COLS-1:0] RedPixels,
  input  logic [ROWS-1:0][COLS-1:0] GrnPixels,
  output logic                      sclk,
  output logic                      sdata,
  output logic                      slatch,
  output logic [3:0]                row_sel,
  output logic                      oe_n,
  output logic                      frame_start
);

  localparam int TMAX = (ON_TIME > DIV) ? ON_TIME : DIV;
  localparam int TW   = $clog2(TMAX + 1);

  scan_state_t              state, next_state;
  logic [3:0]               row, row_nx;
  logic [TW-1:0]            tmr;
  logic [ROWS-1:0][COLS-1:0] red_buf, grn_buf;
  logic                     sh_start, sh_done;
  logic [BITS_PER_ROW-1:0]  sh_word;
  logic                     lat_end, on_end, last_row;

  assign row_nx   = row + 4'd1;
  assign lat_end  = (tmr == TW'(DIV - 1));
  assign on_end   = (tmr == TW'(ON_TIME - 1));
  assign last_row = (row == 4'(ROWS - 1));

  always_comb begin
    next_state = state;
    sh_start   = 1'b0;
    sh_word    = {grn_buf[row_nx], red_buf[row_nx]};
    case (state)
      FRAME: begin
        // Row 0 starts shifting while the buffer is still being loaded.
        next_state = SHIFT;
        sh_start   = 1'b1;
        sh_word    = {GrnPixels[0], RedPixels[0]};
      end
      SHIFT: begin
        if (sh_done) next_state = LATCH;
      end
      LATCH: begin
        if (lat_end) next_state = DISPLAY;
      end
      DISPLAY: begin
        if (on_end) begin
          if (last_row) begin
            next_state = FRAME;
          end else begin
            next_state = SHIFT;
            sh_start   = 1'b1;
          end
        end
      end
      default: next_state = FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FRAME;
      row         <= '0;
      tmr         <= '0;
      red_buf     <= '0;
      grn_buf     <= '0;
      slatch      <= 1'b0;
      row_sel     <= '0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= next_state;
      // Pins follow the state being entered so they line up with it cycle for cycle.
      slatch      <= (next_state == LATCH);
      oe_n        <= (next_state != DISPLAY);
      frame_start <= (state == FRAME);
      if (state == FRAME) begin
        red_buf <= RedPixels;
        grn_buf <= GrnPixels;
        row     <= '0;
      end else if (state == DISPLAY && on_end && !last_row) begin
        row <= row_nx;
      end
      if (state == SHIFT && next_state == LATCH) row_sel <= row;
      if (next_state != state || state == FRAME || state == SHIFT) tmr <= '0;
      else tmr <= tmr + 1'b1;
    end
  end

  led_row_shifter #(
    .DIV(DIV)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (sh_start),
    .word   (sh_word),
    .sclk   (sclk),
    .sdata  (sdata),
    .done   (sh_done)
  );

endmodule

// File: tb/tb_led_matrix_driver.sv
// tb/tb_led_matrix_driver.sv - scoreboard bench for led_matrix_driver at default DIV/ON_TIME
module tb_led_matrix_driver;
  import led_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [15:0][15:0]    RedPixels, GrnPixels;
  logic                 sclk, sdata, slatch, oe_n, frame_start;
  logic [3:0]           row_sel;

  always #5 clk = ~clk;

  led_matrix_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RedPixels  (RedPixels),
    .GrnPixels  (GrnPixels),
    .sclk       (sclk),
    .sdata      (sdata),
    .slatch     (slatch),
    .row_sel    (row_sel),
    .oe_n       (oe_n),
    .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  int rows_checked = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected row word: green col15..0 then red col15..0, first bit shifted is the MSB.
  task automatic push_frame();
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rr;
      rr = 4'(r);
      exp_q.push_back({rr, GrnPixels[r], RedPixels[r]});
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) chk("frame_start_timeout", 0, 1);
    else @(negedge clk);
  endtask

  // Monitor state
  logic        prev_sclk = 1'b0, prev_sdata = 1'b0, prev_slatch = 1'b0, prev_oe = 1'b1, prev_fs = 1'b0;
  logic [31:0] cur_word = '0, lat_word = '0;
  int          cur_bits = 0, lat_bits = 0, lat_len = 0, on_len = 0, hi_len = 0;
  logic [3:0]  on_row = '0;
  logic        row_glitch = 1'b0;
  bit          fs_seen = 1'b0;
  int          fs_gap = 0;
  logic [35:0] e;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("oe_low_outside_display", 32'(!oe_n && (slatch || dut.state != DISPLAY)), 0);
      if (sclk && prev_sclk) chk("sdata_stable_high", 32'(sdata), 32'(prev_sdata));
      if (sclk) hi_len++;
      if (!sclk && prev_sclk) begin
        chk("sclk_high_len", hi_len, 2);
        hi_len = 0;
      end
      if (sclk && !prev_sclk) begin
        cur_word = {cur_word[30:0], sdata};
        cur_bits++;
      end
      if (slatch) begin
        if (!prev_slatch) begin
          lat_word = cur_word;
          lat_bits = cur_bits;
          cur_word = '0;
          cur_bits = 0;
          lat_len  = 0;
        end
        lat_len++;
      end
      if (!oe_n) begin
        if (prev_oe) begin
          on_len = 0;
          on_row = row_sel;
        end
        on_len++;
        if (row_sel !== on_row) row_glitch = 1'b1;
      end
      if (oe_n && !prev_oe && rows_checked < 80) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("row_word", lat_word, e[31:0]);
          chk("row_bits", lat_bits, 32);
          chk("row_sel", 32'(on_row), 32'(e[35:32]));
          chk("on_time", on_len, 64);
          chk("latch_len", lat_len, 2);
          chk("row_sel_stable", 32'(row_glitch), 0);
        end
        row_glitch = 1'b0;
        rows_checked++;
      end
      if (frame_start) begin
        if (prev_fs) chk("frame_start_width", 2, 1);
        if (fs_seen) chk("frame_period", fs_gap, 3105);
        fs_seen = 1'b1;
        fs_gap  = 0;
      end
      fs_gap++;
      prev_sclk   = sclk;
      prev_sdata  = sdata;
      prev_slatch = slatch;
      prev_oe     = oe_n;
      prev_fs     = frame_start;
    end
  end

  initial begin
    int n;
    RedPixels = '0;
    GrnPixels = '0;
    GrnPixels[0][15] = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_slatch", 32'(slatch), 0);
    chk("rst_row_sel", 32'(row_sel), 0);
    chk("rst_frame_start", 32'(frame_start), 0);

    // Frame 0: single green pixel at row 0, col 15
    push_frame();
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_fs();

    // Frame 1: bit-order pattern on red row 5
    RedPixels = '0;
    GrnPixels = '0;
    RedPixels[5] = 16'h8001;
    push_frame();
    wait_fs();

    // Frame 2: all dark; red flips to all-on during row 7 shift and must not tear
    RedPixels = '0;
    GrnPixels = '0;
    push_frame();
    wait_fs();
    repeat (7 * 194 + 50) @(negedge clk);
    RedPixels = '1;
    push_frame();
    wait_fs();

    // Frame 4: random content
    for (int r = 0; r < 16; r++) begin
      RedPixels[r] = 16'($urandom);
      GrnPixels[r] = 16'($urandom);
    end
    push_frame();
    wait_fs();

    n = 0;
    while (rows_checked < 80 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("rows_checked", rows_checked, 80);
    mon_en = 1'b0;

    // Asynchronous reset while row 3 is lit
    n = 0;
    while (!(oe_n == 1'b0 && row_sel == 4'd3) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_row3_display", 32'(oe_n == 1'b0 && row_sel == 4'd3), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_oe_n", 32'(oe_n), 1);
    chk("midreset_sclk", 32'(sclk), 0);
    chk("midreset_slatch", 32'(slatch), 0);
    chk("midreset_row_sel", 32'(row_sel), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("fs_before_edge", 32'(frame_start), 0);
    @(posedge clk);
    #1;
    chk("fs_after_release", 32'(frame_start), 1);
    @(posedge clk);
    #1;
    chk("fs_one_cycle", 32'(frame_start), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
